// File: rtl/garage_gate_ctrl.sv
// garage_gate_ctrl: parking-garage occupancy controller with N timed barrier gates
// Ports:
//   clk, rst_n          control clock, asynchronous active-low reset
//   enter_req_i[N]      one-cycle enter pulses per gate
//   exit_req_i[N]       one-cycle exit pulses per gate
//   remain_o            free spaces (0..CAPACITY)
//   full_o / empty_o    remain==0 / remain==CAPACITY
//   full_led_o          blinks with BLINK_TICKS half-period while full
//   gate_busy_o[N]      barrier in motion
//   gate_dir_o[N]       1 = entering, 0 = exiting (valid while busy)
//   gate_phase_o[2N]    bar animation step 0..3 per gate
//   reject_cnt_o        saturating count of dropped requests
module garage_gate_ctrl #(
    parameter int CAPACITY    = 9,
    parameter int CNT_W       = 4,
    parameter int N_GATES     = 2,
    parameter int GATE_TICKS  = 50,
    parameter int BLINK_TICKS = 25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_GATES-1:0]     enter_req_i,
    input  logic [N_GATES-1:0]     exit_req_i,
    output logic [CNT_W-1:0]       remain_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   full_led_o,
    output logic [N_GATES-1:0]     gate_busy_o,
    output logic [N_GATES-1:0]     gate_dir_o,
    output logic [2*N_GATES-1:0]   gate_phase_o,
    output logic [7:0]             reject_cnt_o
);
    localparam int TW = $clog2(GATE_TICKS);
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
    typedef enum logic [1:0] {IDLE, MOVE_IN, MOVE_OUT} state_e;
    state_e               state_q [N_GATES];
    logic [TW-1:0]        timer_q [N_GATES];
    logic [N_GATES-1:0]   busy_q, dir_q, ex_acc, en_acc;
    logic [2*N_GATES-1:0] phase_q;
    logic [CNT_W-1:0]     remain_q, remain_d;
    logic                 full_q, empty_q, led_q, full_d;
    logic [BW-1:0]        blink_q;
    logic [7:0]           rej_q, rej_d;
    logic [CNT_W:0]       occ, n_ex, n_en;
    logic [4:0]           n_rej;
    logic [8:0]           rej_sum;

    function automatic logic [1:0] phase_of(input logic [TW-1:0] t);
        return 2'((int'(t) * 4) / GATE_TICKS);
    endfunction

    // Exits are granted first so that a car leaving frees a space for an
    // enter in the same cycle; a gate with both requests treats it as an exit.
    always_comb begin
        ex_acc = '0;
        en_acc = '0;
        n_ex   = '0;
        n_en   = '0;
        n_rej  = '0;
        occ    = (CNT_W+1)'(CAPACITY) - {1'b0, remain_q};
        for (int i = 0; i < N_GATES; i++) begin
            if (busy_q[i]) begin
                n_rej = n_rej + 5'(enter_req_i[i]) + 5'(exit_req_i[i]);
            end else if (exit_req_i[i]) begin
                n_rej = n_rej + 5'(enter_req_i[i]);
                if (n_ex < occ) begin
                    ex_acc[i] = 1'b1;
                    n_ex      = n_ex + 1'b1;
                end else begin
                    n_rej = n_rej + 1'b1;
                end
            end
        end
        for (int i = 0; i < N_GATES; i++) begin
            if (!busy_q[i] && enter_req_i[i] && !exit_req_i[i]) begin
                if (n_en < {1'b0, remain_q} + n_ex) begin
                    en_acc[i] = 1'b1;
                    n_en      = n_en + 1'b1;
                end else begin
                    n_rej = n_rej + 1'b1;
                end
            end
        end
        remain_d = CNT_W'({1'b0, remain_q} + n_ex - n_en);
        full_d   = remain_d == '0;
        rej_sum  = {1'b0, rej_q} + 9'(n_rej);
        rej_d    = rej_sum[8] ? 8'hFF : rej_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= CNT_W'(CAPACITY);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            led_q    <= 1'b0;
            blink_q  <= '0;
            rej_q    <= '0;
            busy_q   <= '0;
            dir_q    <= '0;
            phase_q  <= '0;
            for (int i = 0; i < N_GATES; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            remain_q <= remain_d;
            full_q   <= full_d;
            empty_q  <= remain_d == CNT_W'(CAPACITY);
            rej_q    <= rej_d;
            // LED lights on the rising edge of full, then toggles every BLINK_TICKS
            if (full_d && !full_q) begin
                led_q   <= 1'b1;
                blink_q <= '0;
            end else if (full_d) begin
                led_q   <= blink_q == BW'(BLINK_TICKS-1) ? ~led_q : led_q;
                blink_q <= blink_q == BW'(BLINK_TICKS-1) ? '0 : blink_q + 1'b1;
            end else begin
                led_q   <= 1'b0;
                blink_q <= '0;
            end
            for (int i = 0; i < N_GATES; i++) begin
                if (state_q[i] == IDLE) begin
                    if (ex_acc[i] || en_acc[i]) begin
                        state_q[i]        <= ex_acc[i] ? MOVE_OUT : MOVE_IN;
                        timer_q[i]        <= '0;
                        busy_q[i]         <= 1'b1;
                        dir_q[i]          <= en_acc[i];
                        phase_q[2*i +: 2] <= 2'd0;
                    end
                end else if (timer_q[i] == TW'(GATE_TICKS-1)) begin
                    state_q[i]        <= IDLE;
                    timer_q[i]        <= '0;
                    busy_q[i]         <= 1'b0;
                    dir_q[i]          <= 1'b0;
                    phase_q[2*i +: 2] <= 2'd0;
                end else begin
                    timer_q[i]        <= timer_q[i] + 1'b1;
                    phase_q[2*i +: 2] <= phase_of(timer_q[i] + 1'b1);
                end
            end
        end
    end

    assign remain_o     = remain_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign full_led_o   = led_q;
    assign gate_busy_o  = busy_q;
    assign gate_dir_o   = dir_q;
    assign gate_phase_o = phase_q;
    assign reject_cnt_o = rej_q;
endmodule

// File: tb/tb_garage_gate_ctrl.sv
// tb_garage_gate_ctrl: table-driven check of garage_gate_ctrl with CAPACITY=3, 2 gates
module tb_garage_gate_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] enter_req = '0, exit_req = '0;
    logic [3:0] remain;
    logic       full, empty, full_led;
    logic [1:0] gate_busy, gate_dir;
    logic [3:0] gate_phase;
    logic [7:0] reject_cnt;
    int         n_pass = 0, n_total = 0;

    typedef struct {
        logic [1:0] en, ex;
        logic [3:0] r;
        logic       f, e, l;
        logic [1:0] b, d;
        logic [3:0] p;
        logic [7:0] rej;
    } vec_t;
    vec_t vecs[$];

    garage_gate_ctrl #(.CAPACITY(3), .CNT_W(4), .N_GATES(2), .GATE_TICKS(4), .BLINK_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .enter_req_i(enter_req), .exit_req_i(exit_req),
        .remain_o(remain), .full_o(full), .empty_o(empty), .full_led_o(full_led),
        .gate_busy_o(gate_busy), .gate_dir_o(gate_dir), .gate_phase_o(gate_phase),
        .reject_cnt_o(reject_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(logic [3:0] r, logic f, logic e, logic l,
                                       logic [1:0] b, logic [1:0] d, logic [3:0] p, logic [7:0] rej);
        return {9'b0, r, f, e, l, b, d, p, rej};
    endfunction

    task automatic check(input string name, input logic [31:0] exp);
        logic [31:0] act;
        act = pk(remain, full, empty, full_led, gate_busy, gate_dir, gate_phase, reject_cnt);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (remain,full,empty,led,busy,dir,phase,rej)", name, act, exp);
    endtask

    task automatic add(logic [1:0] en, logic [1:0] ex, logic [3:0] r, logic f, logic e, logic l,
                       logic [1:0] b, logic [1:0] d, logic [3:0] p, logic [7:0] rej);
        vecs.push_back('{en, ex, r, f, e, l, b, d, p, rej});
    endtask

    task automatic step(input logic [1:0] en, input logic [1:0] ex);
        enter_req = en;
        exit_req  = ex;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   en     ex     r  f  e  l  busy   dir    phase    rej
        add(2'b00, 2'b00, 3, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 0);
        add(2'b01, 2'b00, 2, 0, 0, 0, 2'b01, 2'b01, 4'b0000, 0);
        add(2'b00, 2'b00, 2, 0, 0, 0, 2'b01, 2'b01, 4'b0001, 0);
        add(2'b00, 2'b00, 2, 0, 0, 0, 2'b01, 2'b01, 4'b0010, 0);
        add(2'b00, 2'b00, 2, 0, 0, 0, 2'b01, 2'b01, 4'b0011, 0);
        add(2'b00, 2'b00, 2, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 0);
        add(2'b11, 2'b00, 0, 1, 0, 1, 2'b11, 2'b11, 4'b0000, 0);
        add(2'b10, 2'b00, 0, 1, 0, 1, 2'b11, 2'b11, 4'b0101, 1);
        add(2'b00, 2'b00, 0, 1, 0, 0, 2'b11, 2'b11, 4'b1010, 1);
        add(2'b00, 2'b00, 0, 1, 0, 0, 2'b11, 2'b11, 4'b1111, 1);
        add(2'b00, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00, 4'b0000, 1);
        add(2'b10, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00, 4'b0000, 2);
        add(2'b00, 2'b01, 1, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 2);
        add(2'b00, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 4'b0001, 2);
        add(2'b00, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 4'b0010, 2);
        add(2'b00, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 4'b0011, 2);
        add(2'b00, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2);
        add(2'b11, 2'b00, 0, 1, 0, 1, 2'b01, 2'b01, 4'b0000, 3);
        add(2'b00, 2'b00, 0, 1, 0, 1, 2'b01, 2'b01, 4'b0001, 3);
        add(2'b00, 2'b00, 0, 1, 0, 0, 2'b01, 2'b01, 4'b0010, 3);
        add(2'b00, 2'b00, 0, 1, 0, 0, 2'b01, 2'b01, 4'b0011, 3);
        add(2'b00, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00, 4'b0000, 3);
        add(2'b10, 2'b01, 0, 1, 0, 1, 2'b11, 2'b10, 4'b0000, 3);
        add(2'b01, 2'b00, 0, 1, 0, 0, 2'b11, 2'b10, 4'b0101, 4);
        add(2'b00, 2'b00, 0, 1, 0, 0, 2'b11, 2'b10, 4'b1010, 4);
        add(2'b00, 2'b00, 0, 1, 0, 1, 2'b11, 2'b10, 4'b1111, 4);
        add(2'b00, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00, 4'b0000, 4);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[k])
            begin
                step(vecs[k].en, vecs[k].ex);
                check($sformatf("vec%0d", k),
                      pk(vecs[k].r, vecs[k].f, vecs[k].e, vecs[k].l, vecs[k].b, vecs[k].d, vecs[k].p, vecs[k].rej));
            end

        // exit starts a motion, then reset is pulled low between clock edges
        step(2'b00, 2'b01);
        check("exit_before_reset", pk(1, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 4));
        step(2'b00, 2'b00);
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_motion", pk(3, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 0));
        @(negedge clk);
        rst_n = 1'b1;

        step(2'b00, 2'b01);
        check("exit_while_empty", pk(3, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 1));

        // two rejected exits per cycle while empty
        repeat (99) step(2'b00, 2'b11);
        check("reject_count_199", pk(3, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 199));
        repeat (51) step(2'b00, 2'b11);
        check("reject_saturate", pk(3, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 255));
        step(2'b11, 2'b11);
        check("reject_hold", pk(3, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 255));
        step(2'b00, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/garage_gate_ctrl.md
Name: garage_gate_ctrl

Overview:
- Parametrised parking-garage occupancy controller with N independent gates.
- Each gate has its own enter and exit request and its own timed barrier-motion FSM.
- Keeps a shared `remain` count, and drives the full/empty flags, a blinking full LED and a rejected-request counter.
- Sits between the debounce/one-pulse stage and the display/LED drivers, and runs on the slow control clock.

Parameters:
- CAPACITY, 9, total spaces; reset value of `remain`; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of `remain`.
- N_GATES, 2, number of gates (1..8).
- GATE_TICKS, 50, clk cycles a barrier stays in motion per accepted car (at least 2).
- BLINK_TICKS, 25, clk cycles per LED half-period while full (at least 1).

Ports:
- clk  in  1  control clock.
- rst_n  in  1  asynchronous active-low reset.
- enter_req  in  N_GATES  single-cycle enter pulses, one bit per gate.
- exit_req  in  N_GATES  single-cycle exit pulses, one bit per gate.
- remain  out  CNT_W  free spaces.
- full  out  1  high when remain==0.
- empty  out  1  high when remain==CAPACITY.
- full_led  out  1  blinks while full.
- gate_busy  out  N_GATES  barrier i in motion.
- gate_dir  out  N_GATES  1 = entering, 0 = exiting; valid only while busy.
- gate_phase  out  2*N_GATES  bar animation step (0..3) per gate, for the display.
- reject_cnt  out  8  saturating count of dropped requests.

Behaviour:
- Reset (async, rst_n=0), all outputs forced:
  - remain=CAPACITY, empty=1, full=0, full_led=0.
  - gate_busy=0, gate_dir=0, gate_phase=0, reject_cnt=0.
  - All timers cleared.
- Reset mid-motion aborts the motion; there is no count rollback beyond returning to CAPACITY.
- Per-gate FSM has three states: IDLE, MOVE_IN, MOVE_OUT.
  - IDLE to MOVE_IN: enter request accepted.
  - IDLE to MOVE_OUT: exit request accepted.
  - MOVE_IN or MOVE_OUT to IDLE: after GATE_TICKS cycles, counted from the cycle after acceptance.
  - gate_busy is high for exactly GATE_TICKS cycles.
  - gate_phase = timer*4/GATE_TICKS, truncated; it starts at 0 and reaches 3 before release.
- Request arbitration, evaluated each cycle on registered state (occ = CAPACITY - remain):
  - A request on a busy gate is dropped and counts a reject.
  - If a gate sees enter and exit in the same cycle, exit wins and the enter counts a reject.
  - Exits are evaluated first, in ascending gate index. An exit is accepted while accepted exits so far < occ; otherwise it is rejected.
  - Enters are evaluated next, in ascending gate index. An enter is accepted while accepted enters so far < remain + accepted exits; otherwise it is rejected.
  - Next remain = remain + exits_accepted - enters_accepted, registered, with one-cycle latency from request.
  - remain never leaves 0..CAPACITY.
- full and empty are registered and change in the same cycle as remain.
- full_led:
  - Toggles every BLINK_TICKS cycles while full=1.
  - The first toggle to 1 happens in the cycle full rises.
  - Forced to 0 in the cycle full falls.
  - The blink counter restarts on each rise of full.
- reject_cnt adds the number of rejected requests in the cycle (can be greater than 1) and saturates at 255.
- Requests outside IDLE never retrigger or extend the timer.

Test Plan:
- CAPACITY=3, N_GATES=2, GATE_TICKS=4, BLINK_TICKS=2 for all cases.
- Reset then idle: remain=3, empty=1, full=0, gate_busy=00, reject_cnt=0.
- enter_req=01 for 1 cycle: next cycle remain=2, gate_busy[0]=1 and gate_dir[0]=1 for 4 cycles, gate_phase[1:0] steps 0,1,2,3, then IDLE.
- Fill to full, then enter_req=10:
  - remain stays 0 and reject_cnt increments by 1.
  - full_led pattern from the full edge is 1,1,0,0,1,1.
  - An exit on gate 0 gives remain=1, full=0 and full_led=0 in the same cycle.
- remain=1, enter_req=11 in the same cycle, both gates idle: gate 0 accepted, gate 1 rejected, remain=0, reject_cnt +1.
- remain=0, exit_req=01 and enter_req=10 in the same cycle: both accepted, remain stays 0, gate 0 MOVE_OUT, gate 1 MOVE_IN.
- Robustness and boundary checks:
  - enter pulse on a busy gate 0: dropped, reject_cnt +1, timer not extended.
  - exit while empty: rejected.
  - rst_n low mid-motion: asynchronous return to reset values.
  - 300 forced rejects: reject_cnt holds at 255.
